// File: rtl/boot_loader_if.sv
// Boot bus bundle: ROM side (boot/addr/data) plus the RAM write port fed by the loader.
interface boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
);
  logic              boot;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;

  // Loader side: owns the bus enable, address and RAM port; only samples data.
  modport master (
    output boot, addr, ram_we, ram_addr, ram_wdata,
    input  data
  );

  // ROM/RAM side: drives data, observes everything else.
  modport slave (
    input  boot, addr, ram_we, ram_addr, ram_wdata,
    output data
  );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: after reset, walks the ROM address range on the shared boot bus,
// copies every word into RAM through a registered write port and accumulates a
// wrapping checksum. The CPU stays held until the full image has been copied.
module boot_loader #(
  parameter int ADDR_W     = 8,
  parameter int WORD_W     = 16,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 46,
  parameter int ADDR_STEP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  boot_loader_if.master     bus,
  output logic [WORD_W-1:0] checksum,
  output logic              cpu_hold,
  output logic              done
);

  localparam logic [ADDR_W-1:0] START_P = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_P   = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] STEP_P  = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  // Checksum accumulation is modulo 2^WORD_W; the carry out is dropped on purpose.
  function automatic logic [WORD_W-1:0] wrap_add(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
    return a + b;
  endfunction

  // The ROM address is the load pointer itself, so it is registered and holds
  // END_ADDR once the image is loaded.
  assign bus.addr = ptr;

  // Load sequencer: state, pointer, RAM write port and status flags all update here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= START_P;
      bus.boot      <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      checksum      <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse following each capture.
      bus.ram_we <= 1'b0;
      case (state)
        IDLE: begin
          state    <= FETCH;
          bus.boot <= 1'b1;
        end
        FETCH: begin
          state <= CAPT;
        end
        CAPT: begin
          bus.ram_wdata <= bus.data;
          bus.ram_addr  <= ptr;
          bus.ram_we    <= 1'b1;
          checksum      <= wrap_add(checksum, bus.data);
          // Compare before incrementing so an END_ADDR at the top of the
          // address space never wraps the pointer back to zero.
          if (ptr == END_P) begin
            state    <= DONE;
            bus.boot <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            ptr   <= ptr + STEP_P;
            state <= FETCH;
          end
        end
        DONE: begin
          if (restart) begin
            state    <= FETCH;
            ptr      <= START_P;
            checksum <= '0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            bus.boot <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table of load scenarios on the default instance, reset
// and restart corner sequences, and two extra instances exercising a range at
// the top of the address space and a single-word image.
module tb_boot_loader;

  localparam int AW = 8;
  localparam int WW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b0;
  logic rst2_n   = 1'b0;
  logic restart  = 1'b0;
  logic restart2 = 1'b0;

  logic [WW-1:0] rom [256];

  boot_loader_if #(.ADDR_W(AW), .WORD_W(WW)) bif ();
  boot_loader_if #(.ADDR_W(AW), .WORD_W(WW)) bif_b ();
  boot_loader_if #(.ADDR_W(AW), .WORD_W(WW)) bif_c ();

  assign bif.data   = rom[bif.addr];
  assign bif_b.data = rom[bif_b.addr];
  assign bif_c.data = rom[bif_c.addr];

  logic [WW-1:0] cs, cs_b, cs_c;
  logic hold, hold_b, hold_c, dn, dn_b, dn_c;

  boot_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .bus(bif.master),
    .checksum(cs), .cpu_hold(hold), .done(dn));

  boot_loader #(.ADDR_W(AW), .WORD_W(WW), .START_ADDR(250), .END_ADDR(254), .ADDR_STEP(2)) dut_b (
    .clk(clk), .rst_n(rst2_n), .restart(restart2), .bus(bif_b.master),
    .checksum(cs_b), .cpu_hold(hold_b), .done(dn_b));

  boot_loader #(.ADDR_W(AW), .WORD_W(WW), .START_ADDR(8), .END_ADDR(8), .ADDR_STEP(2)) dut_c (
    .clk(clk), .rst_n(rst2_n), .restart(restart2), .bus(bif_c.master),
    .checksum(cs_c), .cpu_hold(hold_c), .done(dn_c));

  typedef struct packed {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  wr_t wq[$];
  wr_t wq_b[$];
  wr_t wq_c[$];
  bit  addr0_b = 1'b0;

  // Record every RAM write seen on each instance, and watch for address 0 on the high-range one.
  always @(negedge clk) begin
    if (bif.ram_we)   wq.push_back({bif.ram_addr, bif.ram_wdata});
    if (bif_b.ram_we) wq_b.push_back({bif_b.ram_addr, bif_b.ram_wdata});
    if (bif_c.ram_we) wq_c.push_back({bif_c.ram_addr, bif_c.ram_wdata});
    if (bif_b.boot && bif_b.addr == '0) addr0_b = 1'b1;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic void fill_rom(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       rom[i] = WW'(i * 3);
        1:       rom[i] = 16'hFFFF;
        default: rom[i] = WW'($urandom);
      endcase
    end
  endfunction

  // Reference: the image is the words at s, s+st, ..., e in order; checksum is their sum mod 2^16.
  task automatic verify_writes(input string nm, input wr_t q[$], input int s, input int e,
                               input int st, output logic [WW-1:0] sum);
    int n, bad, a;
    n   = (e - s) / st + 1;
    bad = 0;
    sum = '0;
    for (int k = 0; k < n; k++) begin
      a   = s + k * st;
      sum = sum + rom[a];
      if (k >= q.size()) bad++;
      else if (q[k].a != AW'(a) || q[k].d != rom[a]) bad++;
    end
    check({nm, " write count"}, 64'(q.size()), 64'(n));
    check({nm, " write contents"}, 64'(bad), 64'd0);
  endtask

  // Count rising edges until done is seen high; the bound keeps the run finite.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (dn) break;
    end
  endtask

  task automatic check_reset_main(input string nm);
    check(nm, {bif.boot, bif.addr, bif.ram_we, bif.ram_addr, bif.ram_wdata, cs, hold, dn},
          {1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b1, 1'b0});
  endtask

  typedef struct {
    int            mode;
    int            exp_done;
    bit            cs_fixed;
    logic [WW-1:0] exp_cs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int            edges, eb, ec, pos;
    logic [WW-1:0] model_cs, prev_cs;

    vecs[0] = '{mode: 0, exp_done: 49, cs_fixed: 1'b1, exp_cs: 16'h0678};
    vecs[1] = '{mode: 1, exp_done: 49, cs_fixed: 1'b1, exp_cs: 16'hFFE8};
    vecs[2] = '{mode: 2, exp_done: 49, cs_fixed: 1'b0, exp_cs: 16'h0000};
    vecs[3] = '{mode: 3, exp_done: 49, cs_fixed: 1'b0, exp_cs: 16'h0000};

    // Full loads under several ROM patterns
    for (int v = 0; v < 4; v++) begin
      fill_rom(vecs[v].mode);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_main($sformatf("v%0d reset values", v));
      wq.delete();
      rst_n = 1'b1;
      wait_done(edges);
      #1;
      check($sformatf("v%0d done edge", v), 64'(edges), 64'(vecs[v].exp_done));
      verify_writes($sformatf("v%0d", v), wq, 0, 46, 2, model_cs);
      check($sformatf("v%0d checksum", v), 64'(cs), 64'(model_cs));
      if (vecs[v].cs_fixed)
        check($sformatf("v%0d checksum const", v), 64'(cs), 64'(vecs[v].exp_cs));
      check($sformatf("v%0d done flags", v), {bif.boot, hold, dn}, {1'b0, 1'b0, 1'b1});
      check($sformatf("v%0d addr hold", v), 64'(bif.addr), 64'd46);
      repeat (5) @(negedge clk);
      check($sformatf("v%0d checksum stable", v), 64'(cs), 64'(model_cs));
      check($sformatf("v%0d no extra writes", v), 64'(wq.size()), 64'd24);
    end

    // Asynchronous reset in the middle of a load
    fill_rom(2);
    rst_n = 1'b0;
    @(negedge clk);
    wq.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 100 && wq.size() < 5; i++) @(negedge clk);
    check("midreset reached 5 writes", 64'(wq.size()), 64'd5);
    #2 rst_n = 1'b0;
    #1 check_reset_main("midreset async values");
    repeat (2) @(negedge clk);
    check_reset_main("midreset held values");
    wq.delete();
    rst_n = 1'b1;
    wait_done(edges);
    #1;
    check("midreset done edge", 64'(edges), 64'd49);
    verify_writes("midreset reload", wq, 0, 46, 2, model_cs);
    check("midreset checksum", 64'(cs), 64'(model_cs));

    // restart outside DONE is ignored
    fill_rom(3);
    rst_n = 1'b0;
    @(negedge clk);
    wq.delete();
    rst_n = 1'b1;
    pos = int'($urandom_range(2, 40));
    fork
      wait_done(edges);
      begin
        repeat (pos) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
      end
    join
    #1;
    check("restart-mid done edge", 64'(edges), 64'd49);
    verify_writes("restart-mid", wq, 0, 46, 2, model_cs);
    check("restart-mid checksum", 64'(cs), 64'(model_cs));
    prev_cs = model_cs;

    // restart in DONE reloads the whole image
    repeat (3) @(negedge clk);
    wq.delete();
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
    check("restart-done flags", {dn, hold, cs, bif.boot, bif.addr},
          {1'b0, 1'b1, 16'd0, 1'b1, 8'd0});
    wait_done(edges);
    #1;
    check("restart-done done edge", 64'(edges + 1), 64'd49);
    verify_writes("restart-done", wq, 0, 46, 2, model_cs);
    check("restart-done checksum", 64'(cs), 64'(prev_cs));

    // High address range and single-word image
    fill_rom(2);
    check("inst b/c reset", {bif_b.addr, bif_c.addr, bif_b.boot, bif_c.boot, dn_b, dn_c, hold_b, hold_c},
          {8'd250, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    wq_b.delete();
    wq_c.delete();
    rst2_n = 1'b1;
    eb = 0;
    ec = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (dn_b && eb == 0) eb = e;
      if (dn_c && ec == 0) ec = e;
    end
    #1;
    check("high-range done edge", 64'(eb), 64'd7);
    check("single-word done edge", 64'(ec), 64'd3);
    verify_writes("high-range", wq_b, 250, 254, 2, model_cs);
    check("high-range checksum", 64'(cs_b), 64'(model_cs));
    verify_writes("single-word", wq_c, 8, 8, 2, model_cs);
    check("single-word checksum", 64'(cs_c), 64'(model_cs));
    check("high-range addr never 0", 64'(addr0_b), 64'd0);
    check("high-range final", {bif_b.addr, bif_b.boot, hold_b}, {8'd254, 1'b0, 1'b0});
    check("single-word final", {bif_c.addr, bif_c.boot, hold_c}, {8'd8, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
